// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp controller.
// The state enum always lists FAULT; it is only reachable when PWM_RAMP_FAULT_EN is defined.
package pwm_pkg;

  localparam int DUTY_W_DEFAULT = 8;
  localparam int DIV_W_DEFAULT  = 8;

  // Length of one PWM generator period in clk cycles (8-bit counter wrap).
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_FAULT = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_step_timer.sv
// Counts PWM period boundaries and pulses step_tick on every interval-th one.
// Held cleared while the controller is not ramping.
module pwm_step_timer
  import pwm_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] interval,
  input  logic             period_end,
  output logic             step_tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic             last;

  // interval is never 0 here; the controller substitutes 1 on accept.
  assign last      = (cnt == (interval - ONE));
  assign step_tick = !clear && period_end && last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (period_end) begin
      cnt <= last ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Slews the PWM duty toward a requested target in fixed steps, only on period boundaries.
// Optional fault handling is compiled in with PWM_RAMP_FAULT_EN.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEFAULT,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_end,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [DUTY_W-1:0] step,
  input  logic [DIV_W-1:0]  interval,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
`ifdef PWM_RAMP_FAULT_EN
  ,
  input  logic              fault,
  input  logic              fault_clr,
  output logic              fault_latched
`endif
);

  ramp_state_e       state, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] tgt_q, step_q;
  logic [DIV_W-1:0]  intv_q;

  logic fault_req, fault_clr_req;
  logic accept, load, at_target, step_tick;

`ifdef PWM_RAMP_FAULT_EN
  assign fault_req     = fault;
  assign fault_clr_req = fault_clr && !fault;
  assign fault_latched = (state == ST_FAULT);
`else
  // Without fault support FAULT is unreachable; a forced clear lets it fall back to IDLE.
  assign fault_req     = 1'b0;
  assign fault_clr_req = 1'b1;
`endif

  assign tgt_ready = (state == ST_IDLE);
  assign accept    = tgt_valid && tgt_ready;
  assign at_target = (duty == tgt_q);

  // done coincides with the first cycle the final duty is visible; busy drops with it.
  assign done = (state == ST_RAMP) && at_target && !fault_req;
  assign busy = (state == ST_RAMP) && !at_target;

  pwm_step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != ST_RAMP),
    .interval   (intv_q),
    .period_end (period_end),
    .step_tick  (step_tick)
  );

  // Saturating step: the distance to the target is compared in one extra bit so the
  // last step lands exactly on the target instead of overshooting or wrapping.
  logic              up;
  logic [DUTY_W:0]   gap;
  logic [DUTY_W-1:0] moved, duty_stepped;

  always_comb begin
    up           = (tgt_q > duty);
    gap          = up ? ({1'b0, tgt_q} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, tgt_q});
    moved        = up ? (duty + step_q) : (duty - step_q);
    duty_stepped = (gap <= {1'b0, step_q}) ? tgt_q : moved;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    duty_d  = duty;
    load    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RAMP;
          load    = 1'b1;
        end
      end
      ST_RAMP: begin
        if (at_target) begin
          state_d = ST_IDLE;
        end else if (step_tick) begin
          duty_d = duty_stepped;
        end
      end
      ST_FAULT: begin
        if (fault_clr_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fault overrides every state and kills the output at once, not on a period boundary.
    if (fault_req) begin
      state_d = ST_FAULT;
      duty_d  = '0;
      load    = 1'b0;
    end
  end

  // NOTE: the latched request registers are reset too, so state after reset never depends on X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      duty   <= '0;
      tgt_q  <= '0;
      step_q <= '0;
      intv_q <= '0;
    end else begin
      state <= state_d;
      duty  <= duty_d;
      if (load) begin
        tgt_q  <= tgt_duty;
        step_q <= (step == '0) ? DUTY_W'(1) : step;
        intv_q <= (interval == '0) ? DIV_W'(1) : interval;
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench for pwm_ramp_controller: table of ramps, corner sequences, random vs model.
// Exercises the fault path too when PWM_RAMP_FAULT_EN is defined.
`timescale 1ns/1ps
module tb_pwm_ramp_controller;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       period_end = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [7:0] tgt_duty = '0;
  logic [7:0] step = '0;
  logic [7:0] interval = '0;
  logic [7:0] duty;
  logic       busy;
  logic       done;
`ifdef PWM_RAMP_FAULT_EN
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault_latched;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_ramp_controller #(.DUTY_W(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .period_end (period_end),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_duty   (tgt_duty),
    .step       (step),
    .interval   (interval),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
`ifdef PWM_RAMP_FAULT_EN
    ,
    .fault         (fault),
    .fault_clr     (fault_clr),
    .fault_latched (fault_latched)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  // Reference step rule: move toward the target by s, landing exactly on it when close.
  function automatic int toward(input int d, input int t, input int s);
    if (t > d) return (t - d <= s) ? t : d + s;
    else       return (d - t <= s) ? t : d - s;
  endfunction

  // Accept one target, then run period_end every PWM_PERIOD cycles until done.
  // Counts duty changes, periods seen, done pulses, and protocol violations.
  task automatic run_ramp(input logic [7:0] t, input logic [7:0] s, input logic [7:0] iv,
                          input bit inject, output int upd, output int per, output int dn,
                          output int bad, output int to);
    logic [7:0] prev;
    bit         pe_prev;
    int         phase;
    upd = 0; per = 0; dn = 0; bad = 0; to = 1; phase = 0;
    tgt_duty = t; step = s; interval = iv; tgt_valid = 1'b1; period_end = 1'b0;
    tick();
    tgt_valid = 1'b0;
    prev = duty;
    pe_prev = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (duty !== prev) begin
        upd++;
        if (!pe_prev) bad++;
      end
      prev = duty;
      if (done === 1'b1) begin
        dn++;
        if (busy !== 1'b0 || tgt_ready !== 1'b0) bad++;
        tick();
        if (done !== 1'b0 || busy !== 1'b0 || tgt_ready !== 1'b1) bad++;
        to = 0;
        break;
      end
      if (tgt_ready !== 1'b0 || busy !== 1'b1) bad++;
      phase++;
      period_end = (phase % PWM_PERIOD == 0);
      if (period_end) per++;
      tgt_valid = inject && (c == 300);
      if (tgt_valid) tgt_duty = 8'd128;
      pe_prev = period_end;
      tick();
    end
    period_end = 1'b0;
    tgt_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] t;
    logic [7:0] s;
    logic [7:0] iv;
    bit         inject;
    int         upd;
    int         per;
    int         fin;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int upd, per, dn, bad, to;
    bit m_ramp;
    int m_duty, m_tgt, m_step, m_int, m_pe;
    logic [10:0] exp_vec;
    bit exp_done;

    // Chained ramps starting from duty=0 after reset.
    tbl[0] = '{8'd64,  8'd16,  8'd1, 1'b0, 4, 4,  64};
    tbl[1] = '{8'd0,   8'd10,  8'd2, 1'b0, 7, 14, 0};
    tbl[2] = '{8'd250, 8'd250, 8'd1, 1'b0, 1, 1,  250};
    tbl[3] = '{8'd255, 8'd10,  8'd1, 1'b0, 1, 1,  255};
    tbl[4] = '{8'd255, 8'd7,   8'd3, 1'b0, 0, 0,  255};
    tbl[5] = '{8'd253, 8'd0,   8'd1, 1'b0, 2, 2,  253};
    tbl[6] = '{8'd250, 8'd1,   8'd0, 1'b0, 3, 3,  250};
    tbl[7] = '{8'd200, 8'd25,  8'd1, 1'b1, 2, 2,  200};
    tbl[8] = '{8'd5,   8'd255, 8'd1, 1'b0, 1, 1,  5};
    tbl[9] = '{8'd0,   8'd3,   8'd1, 1'b0, 2, 2,  0};

    // Reset values, observed while reset is held.
    #3;
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", tgt_ready, 1);
`ifdef PWM_RAMP_FAULT_EN
    check("rst_fault_latched", fault_latched, 0);
`endif
    do_reset();

    for (int i = 0; i < 10; i++) begin
      check($sformatf("v%0d_ready_before", i), tgt_ready, 1);
      run_ramp(tbl[i].t, tbl[i].s, tbl[i].iv, tbl[i].inject, upd, per, dn, bad, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_updates", i), upd, tbl[i].upd);
      check($sformatf("v%0d_periods", i), per, tbl[i].per);
      check($sformatf("v%0d_final_duty", i), duty, tbl[i].fin);
      check($sformatf("v%0d_done_pulses", i), dn, 1);
      check($sformatf("v%0d_violations", i), bad, 0);
    end

    // A period_end in the accept cycle is not counted.
    tgt_duty = 8'd100; step = 8'd50; interval = 8'd1;
    tgt_valid = 1'b1; period_end = 1'b1;
    tick();
    tgt_valid = 1'b0; period_end = 1'b0;
    check("acc_pe_duty", duty, 0);
    check("acc_pe_busy", busy, 1);
    tick();
    check("acc_pe_duty_hold", duty, 0);
    pulse_pe();
    check("acc_pe_first_step", duty, 50);
    check("acc_pe_no_done", done, 0);
    pulse_pe();
    check("acc_pe_final", duty, 100);
    check("acc_pe_done", done, 1);
    check("acc_pe_busy_low", busy, 0);
    tick();
    check("acc_pe_ready_after", tgt_ready, 1);

    // Equal target: done one cycle after accept, duty untouched.
    tgt_duty = 8'd100; step = 8'd9; interval = 8'd4; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    check("eq_done", done, 1);
    check("eq_duty", duty, 100);
    check("eq_busy", busy, 0);
    check("eq_ready_low", tgt_ready, 0);
    tick();
    check("eq_done_clear", done, 0);
    check("eq_ready", tgt_ready, 1);

    // Asynchronous reset mid-ramp at duty=96.
    do_reset();
    tgt_duty = 8'd200; step = 8'd32; interval = 8'd1; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    pulse_pe();
    pulse_pe();
    pulse_pe();
    check("mid_rst_pre_duty", duty, 96);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_duty", duty, 0);
    check("mid_rst_ready", tgt_ready, 1);
    check("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_after_duty", duty, 0);

`ifdef PWM_RAMP_FAULT_EN
    // Fault mid-ramp at duty=80, blocked requests, clear, then a fresh ramp.
    tgt_duty = 8'd200; step = 8'd16; interval = 8'd1; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    for (int k = 0; k < 5; k++) pulse_pe();
    check("flt_pre_duty", duty, 80);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check("flt_duty", duty, 0);
    check("flt_latched", fault_latched, 1);
    check("flt_busy", busy, 0);
    check("flt_done", done, 0);
    check("flt_ready", tgt_ready, 0);
    tgt_duty = 8'd32; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    check("flt_ignore_latched", fault_latched, 1);
    check("flt_ignore_busy", busy, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("flt_clr_latched", fault_latched, 0);
    check("flt_clr_ready", tgt_ready, 1);
    check("flt_clr_duty", duty, 0);
    run_ramp(8'd32, 8'd16, 8'd1, 1'b0, upd, per, dn, bad, to);
    check("flt_ramp_timeout", to, 0);
    check("flt_ramp_updates", upd, 2);
    check("flt_ramp_final", duty, 32);
    check("flt_ramp_done", dn, 1);
    check("flt_ramp_violations", bad, 0);
`endif

    // Random traffic against a period-counting reference model.
    do_reset();
    m_ramp = 1'b0; m_duty = 0; m_tgt = 0; m_step = 1; m_int = 1; m_pe = 0;
    for (int c = 0; c < 6000; c++) begin
      period_end = ($urandom_range(0, 3) == 0);
      tgt_valid  = ($urandom_range(0, 2) == 0);
      tgt_duty   = 8'($urandom);
      step       = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      interval   = 8'($urandom_range(0, 3));
      #1;
      exp_done = m_ramp && (m_duty == m_tgt);
      exp_vec = {!m_ramp, m_ramp && !exp_done, exp_done, 8'(m_duty)};
      check($sformatf("rand_c%0d_{ready,busy,done,duty}", c),
            {tgt_ready, busy, done, duty}, exp_vec);
      if (!m_ramp) begin
        if (tgt_valid) begin
          m_ramp = 1'b1;
          m_tgt  = int'(tgt_duty);
          m_step = (step == 0) ? 1 : int'(step);
          m_int  = (interval == 0) ? 1 : int'(interval);
          m_pe   = 0;
        end
      end else if (m_duty == m_tgt) begin
        m_ramp = 1'b0;
      end else if (period_end) begin
        m_pe++;
        if (m_pe % m_int == 0) m_duty = toward(m_duty, m_tgt, m_step);
      end
      tick();
    end
    period_end = 1'b0;
    tgt_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
